// File: rtl/mux_sel_sequencer_pkg.sv
// Shared encodings for the mux select sequencer: FSM states, channel codes
// and the helper used to rotate round-robin search candidates.
package mux_sel_sequencer_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  typedef logic [CH_W-1:0] ch_t;

  // Channel code {s0,s1} selects mux data input d0..d3.
  localparam ch_t CH_D0 = 2'b00;
  localparam ch_t CH_D1 = 2'b01;
  localparam ch_t CH_D2 = 2'b10;
  localparam ch_t CH_D3 = 2'b11;

  // Channel 'off' positions after 'base', wrapping modulo NUM_CH.
  function automatic ch_t ch_after(input ch_t base, input ch_t off);
    return ch_t'(base + off);
  endfunction

endpackage

// File: rtl/mux_sel_sequencer_rr_pick4.sv
// Combinational round-robin picker: first set request searching from last+1
// through last (mod 4); 'any' flags that some channel is requesting.
module rr_pick4
  import mux_sel_sequencer_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  ch_t               last,
  output ch_t               pick,
  output logic              any
);

  ch_t               cand [NUM_CH];
  logic [NUM_CH-1:0] hit;

  // cand[gi] is the channel examined at search position gi; the last slot
  // wraps back to 'last' itself so a lone requester is always found.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cand
      assign cand[gi] = ch_after(last, ch_t'(gi + 1));
      assign hit[gi]  = req[cand[gi]];
    end
  endgenerate

  always_comb begin
    pick = last;
    any  = |req;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (hit[i]) begin
        pick = cand[i];
      end
    end
  end

endmodule

// File: rtl/mux_sel_sequencer.sv
// Round-robin select generator for a 4:1 mux: grants a requesting channel,
// holds registered selects for a latched dwell, and stalls on consumer ready.
module mux_sel_sequencer
  import mux_sel_sequencer_pkg::*;
#(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_CH-1:0]  req,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               ready,
  output logic               s0,
  output logic               s1,
  output logic               sel_valid,
  output logic               ch_done
);

  state_t             state_reg, state_next;
  ch_t                ch_reg, ch_next;
  ch_t                last_reg, last_next;
  logic               sel_valid_reg, sel_valid_next;
  logic               ch_done_reg, ch_done_next;
  logic [DWELL_W-1:0] cnt_reg, cnt_next;
  logic [DWELL_W-1:0] dwell_reg, dwell_next;

  logic [DWELL_W-1:0] dwell_eff;
  logic               cnt_end;
  ch_t                pick_last;
  ch_t                pick;
  logic               pick_any;

  assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
  // >= rather than == keeps the counter pinned even if it ever overshoots.
  assign cnt_end   = (cnt_reg >= dwell_reg - DWELL_W'(1));

  // While holding, the search starts after the channel being released so a
  // regrant on the same edge already sees the updated last pointer.
  assign pick_last = (state_reg == ST_HOLD) ? ch_reg : last_reg;

  rr_pick4 u_pick (
    .req  (req),
    .last (pick_last),
    .pick (pick),
    .any  (pick_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      ch_reg        <= CH_D0;
      last_reg      <= CH_D3;
      sel_valid_reg <= 1'b0;
      ch_done_reg   <= 1'b0;
      cnt_reg       <= '0;
      dwell_reg     <= DWELL_W'(1);
    end else begin
      state_reg     <= state_next;
      ch_reg        <= ch_next;
      last_reg      <= last_next;
      sel_valid_reg <= sel_valid_next;
      ch_done_reg   <= ch_done_next;
      cnt_reg       <= cnt_next;
      dwell_reg     <= dwell_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    ch_next        = ch_reg;
    last_next      = last_reg;
    sel_valid_next = sel_valid_reg;
    ch_done_next   = 1'b0;
    cnt_next       = cnt_reg;
    dwell_next     = dwell_reg;

    case (state_reg)
      ST_IDLE: begin
        sel_valid_next = 1'b0;
        if (en && pick_any) begin
          ch_next        = pick;
          sel_valid_next = 1'b1;
          cnt_next       = '0;
          dwell_next     = dwell_eff;
          state_next     = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (!cnt_end) begin
          cnt_next = cnt_reg + DWELL_W'(1);
        end else if (ready) begin
          ch_done_next = 1'b1;
          last_next    = ch_reg;
          if (en && pick_any) begin
            ch_next        = pick;
            sel_valid_next = 1'b1;
            cnt_next       = '0;
            dwell_next     = dwell_eff;
          end else begin
            // Selects keep their last value so the mux output stays put.
            sel_valid_next = 1'b0;
            state_next     = ST_IDLE;
          end
        end
      end

      default: begin
        state_next     = ST_IDLE;
        sel_valid_next = 1'b0;
      end
    endcase
  end

  assign s0        = ch_reg[1];
  assign s1        = ch_reg[0];
  assign sel_valid = sel_valid_reg;
  assign ch_done   = ch_done_reg;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Directed bench for mux_sel_sequencer; observed word is {s0,s1,sel_valid,ch_done}.
module tb_mux_sel_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic [3:0] dwell;
  logic       ready;
  logic       s0, s1, sel_valid, ch_done;
  logic [3:0] obs;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  assign obs = {s0, s1, sel_valid, ch_done};

  mux_sel_sequencer #(.DWELL_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .dwell     (dwell),
    .ready     (ready),
    .s0        (s0),
    .s1        (s1),
    .sel_valid (sel_valid),
    .ch_done   (ch_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; req = 4'b0; dwell = 4'd0; ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; req = 4'b0; dwell = 4'd0; ready = 1'b0;
    #2;
    total_cnt++;
    if (obs !== 4'b0000) $display("FAIL reset_async obs=%b exp=0000", obs);
    else pass_cnt++;
    step();
    step();
    rst = 1'b0; en = 1'b1; ready = 1'b1; dwell = 4'd3;
    for (int i = 0; i < 4; i++) begin
      step();
      total_cnt++;
      if (obs !== 4'b0000) $display("FAIL reset_idle[%0d] obs=%b exp=0000", i, obs);
      else pass_cnt++;
    end
  endtask

  task automatic test_lone_regrant();
    logic [3:0] exp_seq [7] = '{4'b1010, 4'b1010, 4'b1010, 4'b1011,
                                4'b1010, 4'b1010, 4'b1011};
    do_reset();
    en = 1'b1; req = 4'b0100; dwell = 4'd3; ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      total_cnt++;
      if (obs !== exp_seq[i]) $display("FAIL lone_regrant[%0d] obs=%b exp=%b", i, obs, exp_seq[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_seq [5] = '{4'b0010, 4'b0111, 4'b1011, 4'b1111, 4'b0011};
    do_reset();
    en = 1'b1; req = 4'b1111; dwell = 4'd1; ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      total_cnt++;
      if (obs !== exp_seq[i]) $display("FAIL rr_order[%0d] obs=%b exp=%b", i, obs, exp_seq[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_stall();
    logic [3:0] exp_seq [8] = '{4'b0110, 4'b0110, 4'b0110, 4'b0110,
                                4'b0110, 4'b0110, 4'b0110, 4'b0111};
    do_reset();
    en = 1'b1; req = 4'b0010; dwell = 4'd2; ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      total_cnt++;
      if (obs !== exp_seq[i]) $display("FAIL stall[%0d] obs=%b exp=%b", i, obs, exp_seq[i]);
      else pass_cnt++;
      if (i == 6) ready = 1'b1;
    end
  endtask

  task automatic test_dwell();
    logic [3:0] exp_zero [4] = '{4'b0010, 4'b0011, 4'b0011, 4'b0011};
    logic [3:0] exp_chg  [8] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010,
                                 4'b0010, 4'b0011, 4'b0010, 4'b0011};
    do_reset();
    en = 1'b1; req = 4'b0001; dwell = 4'd0; ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total_cnt++;
      if (obs !== exp_zero[i]) $display("FAIL dwell_zero[%0d] obs=%b exp=%b", i, obs, exp_zero[i]);
      else pass_cnt++;
    end
    do_reset();
    en = 1'b1; req = 4'b0001; dwell = 4'd5; ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      total_cnt++;
      if (obs !== exp_chg[i]) $display("FAIL dwell_change[%0d] obs=%b exp=%b", i, obs, exp_chg[i]);
      else pass_cnt++;
      if (i == 0) dwell = 4'd2;
    end
  endtask

  task automatic test_max_dwell();
    logic [3:0] exp_val;
    do_reset();
    en = 1'b1; req = 4'b0100; dwell = 4'd15; ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      exp_val = (i == 15) ? 4'b1011 : 4'b1010;
      total_cnt++;
      if (obs !== exp_val) $display("FAIL max_dwell[%0d] obs=%b exp=%b", i, obs, exp_val);
      else pass_cnt++;
    end
  endtask

  task automatic test_abort_and_en_drop();
    logic [3:0] exp_seq [6] = '{4'b1110, 4'b1110, 4'b1110, 4'b1101, 4'b1100, 4'b1100};
    do_reset();
    en = 1'b1; req = 4'b0100; dwell = 4'd4; ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++;
      if (obs !== 4'b1010) $display("FAIL pre_abort[%0d] obs=%b exp=1010", i, obs);
      else pass_cnt++;
    end
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if (obs !== 4'b0000) $display("FAIL abort_async obs=%b exp=0000", obs);
    else pass_cnt++;
    step();
    total_cnt++;
    if (obs !== 4'b0000) $display("FAIL abort_held obs=%b exp=0000", obs);
    else pass_cnt++;
    rst = 1'b0; req = 4'b1000; dwell = 4'd3; en = 1'b1; ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      total_cnt++;
      if (obs !== exp_seq[i]) $display("FAIL en_drop[%0d] obs=%b exp=%b", i, obs, exp_seq[i]);
      else pass_cnt++;
      if (i == 0) begin
        en  = 1'b0;
        req = 4'b0000;
      end
    end
  endtask

  initial begin
    test_reset();
    test_lone_regrant();
    test_back_to_back();
    test_stall();
    test_dwell();
    test_max_dwell();
    test_abort_and_en_drop();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
